// File: rtl/selection_engine.sv
// Parent selection stage: latches a population and its fitness bank, then picks
// SEL_SIZE parents one at a time, either elitist (lowest distinct) or by LFSR tournament.
module selection_engine #(
  parameter int POP_SIZE  = 50,
  parameter int SEL_SIZE  = 10,
  parameter int GENOME_W  = 150,
  parameter int FIT_W     = 12,
  parameter int TOUR_SIZE = 4,
  localparam int IDX_W    = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         mode,
  input  logic [POP_SIZE*GENOME_W-1:0] pop,
  input  logic [POP_SIZE*FIT_W-1:0]    fit,
  input  logic [31:0]                  prg_seed,
  output logic [SEL_SIZE*GENOME_W-1:0] sel_pop,
  output logic [SEL_SIZE*IDX_W-1:0]    sel_idx,
  output logic [FIT_W-1:0]             best_fit,
  output logic                         busy,
  output logic                         done
);

  localparam int KW = (SEL_SIZE > 1) ? $clog2(SEL_SIZE) : 1;
  localparam int DW = $clog2(TOUR_SIZE + 1);
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  if (SEL_SIZE > POP_SIZE || SEL_SIZE < 1) begin : g_bad_sel
    $error("selection_engine: SEL_SIZE must be in 1..POP_SIZE");
  end
  if (TOUR_SIZE < 1) begin : g_bad_tour
    $error("selection_engine: TOUR_SIZE must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_DRAW, S_COMMIT, S_DONE} state_t;

  state_t state_q, state_d;

  logic [POP_SIZE-1:0][GENOME_W-1:0] pop_q;
  logic [POP_SIZE-1:0][FIT_W-1:0]    fit_q;
  logic                              mode_q;
  logic [31:0]                       lfsr_q, lfsr_nx;
  logic [POP_SIZE-1:0]               taken_q;
  logic [IDX_W-1:0]                  i_q, cur_idx_q, cand;
  logic [FIT_W-1:0]                  cur_fit_q, best_fit_q;
  logic                              have_best_q;
  logic [DW-1:0]                     d_cnt_q;
  logic [KW-1:0]                     k_q;
  logic [SEL_SIZE-1:0][GENOME_W-1:0] sel_pop_q;
  logic [SEL_SIZE-1:0][IDX_W-1:0]    sel_idx_q;
  logic                              done_q;
  logic                              in_range, cand_ok, better;

  // Galois right-shift step; the low index bits of the stepped value are the draw.
  assign lfsr_nx  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
  assign cand     = (state_q == S_DRAW) ? lfsr_nx[IDX_W-1:0] : i_q;
  assign in_range = (32'(cand) < 32'(POP_SIZE));
  assign cand_ok  = (state_q == S_DRAW) ? in_range : (in_range && !taken_q[cand]);
  // have_best lets the first eligible candidate win even at full-scale fitness.
  assign better   = cand_ok && (!have_best_q || (fit_q[cand] < cur_fit_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   state_d = mode ? S_DRAW : S_SCAN;
      S_SCAN:   if (32'(i_q) == 32'(POP_SIZE - 1)) state_d = S_COMMIT;
      S_DRAW:   if (cand_ok && (32'(d_cnt_q) == 32'(TOUR_SIZE - 1))) state_d = S_COMMIT;
      S_COMMIT: begin
        if (32'(k_q) == 32'(SEL_SIZE - 1)) state_d = S_DONE;
        else                               state_d = mode_q ? S_DRAW : S_SCAN;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_q       <= '0;
      fit_q       <= '0;
      mode_q      <= 1'b0;
      lfsr_q      <= '0;
      taken_q     <= '0;
      i_q         <= '0;
      cur_idx_q   <= '0;
      cur_fit_q   <= '0;
      have_best_q <= 1'b0;
      d_cnt_q     <= '0;
      k_q         <= '0;
      best_fit_q  <= '0;
      sel_pop_q   <= '0;
      sel_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_LOAD: begin
          pop_q       <= pop;
          fit_q       <= fit;
          mode_q      <= mode;
          lfsr_q      <= (prg_seed == 32'h0) ? 32'h1 : prg_seed;
          taken_q     <= '0;
          i_q         <= '0;
          d_cnt_q     <= '0;
          k_q         <= '0;
          have_best_q <= 1'b0;
        end
        S_SCAN: begin
          i_q <= i_q + 1'b1;
          if (better) begin
            cur_fit_q   <= fit_q[cand];
            cur_idx_q   <= cand;
            have_best_q <= 1'b1;
          end
        end
        S_DRAW: begin
          lfsr_q <= lfsr_nx;
          if (cand_ok) d_cnt_q <= d_cnt_q + 1'b1;
          if (better) begin
            cur_fit_q   <= fit_q[cand];
            cur_idx_q   <= cand;
            have_best_q <= 1'b1;
          end
        end
        S_COMMIT: begin
          sel_pop_q[k_q] <= pop_q[cur_idx_q];
          sel_idx_q[k_q] <= cur_idx_q;
          if (!mode_q) taken_q[cur_idx_q] <= 1'b1;
          if (k_q == '0 || cur_fit_q < best_fit_q) best_fit_q <= cur_fit_q;
          k_q         <= k_q + 1'b1;
          i_q         <= '0;
          d_cnt_q     <= '0;
          have_best_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign sel_pop  = sel_pop_q;
  assign sel_idx  = sel_idx_q;
  assign best_fit = best_fit_q;
  assign done     = done_q;
  assign busy     = (state_q == S_LOAD) || (state_q == S_SCAN) ||
                    (state_q == S_DRAW) || (state_q == S_COMMIT);

endmodule
